// File: rtl/uart_tx_framer.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_framer
// Description : UART transmitter. One-word holding register feeding a shift
//               register that emits start/data/parity/stop, one bit per clock.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_framer #(
  parameter int P_UART_DATA_WIDTH = 8,
  parameter int P_UART_STOP_WIDTH = 1,
  parameter int P_UART_CHECK      = 0
) (
  input  logic                         i_u_clk,
  input  logic                         i_u_rst_n,
  input  logic [P_UART_DATA_WIDTH-1:0] i_uart_tx_data,
  input  logic                         i_uart_tx_valid,
  output logic                         o_uart_tx_ready,
  output logic                         o_uart_tx,
  output logic                         o_uart_tx_busy
);

  localparam logic [3:0] c_last_data = 4'(P_UART_DATA_WIDTH - 1);
  localparam logic [3:0] c_last_stop = 4'(P_UART_STOP_WIDTH - 1);

  if (P_UART_DATA_WIDTH < 5 || P_UART_DATA_WIDTH > 8) begin : g_bad_data_width
    $error("uart_tx_framer: P_UART_DATA_WIDTH must be 5..8");
  end
  if (P_UART_STOP_WIDTH < 1 || P_UART_STOP_WIDTH > 2) begin : g_bad_stop_width
    $error("uart_tx_framer: P_UART_STOP_WIDTH must be 1..2");
  end
  if (P_UART_CHECK < 0 || P_UART_CHECK > 2) begin : g_bad_check
    $error("uart_tx_framer: P_UART_CHECK must be 0, 1 or 2");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t                         r_state;
  logic [P_UART_DATA_WIDTH-1:0]   r_hold_data;
  logic                           r_hold_full;
  logic [P_UART_DATA_WIDTH-1:0]   r_shift;
  logic [3:0]                     r_cnt;
  logic                           r_par;
  logic                           r_tx;
  logic                           r_busy;
  logic                           r_ready;
  logic                           w_accept;

  // r_ready always mirrors ~r_hold_full, so an accept can never hit a full holding register
  assign w_accept = i_uart_tx_valid & r_ready;

  // Each state's line value is registered on the edge that state is acted on,
  // so the start bit appears one edge after the load from the holding register.
  always_ff @(posedge i_u_clk or negedge i_u_rst_n) begin
    if (!i_u_rst_n) begin
      r_state     <= S_IDLE;
      r_hold_data <= '0;
      r_hold_full <= 1'b0;
      r_shift     <= '0;
      r_cnt       <= 4'd0;
      r_par       <= 1'b0;
      r_tx        <= 1'b1;
      r_busy      <= 1'b0;
      r_ready     <= 1'b1;
    end else begin
      if (w_accept) begin
        r_hold_data <= i_uart_tx_data;
        r_hold_full <= 1'b1;
        r_ready     <= 1'b0;
      end
      case (r_state)
        S_IDLE: begin
          r_tx   <= 1'b1;
          r_busy <= 1'b0;
          if (r_hold_full) begin
            r_shift     <= r_hold_data;
            r_hold_full <= 1'b0;
            r_ready     <= 1'b1;
            r_state     <= S_START;
          end
        end
        S_START: begin
          r_tx    <= 1'b0;
          r_busy  <= 1'b1;
          r_cnt   <= 4'd0;
          r_par   <= 1'b0;
          r_state <= S_DATA;
        end
        S_DATA: begin
          r_tx    <= r_shift[0];
          r_busy  <= 1'b1;
          r_shift <= r_shift >> 1;
          r_par   <= r_par ^ r_shift[0];
          if (r_cnt == c_last_data) begin
            r_cnt   <= 4'd0;
            r_state <= (P_UART_CHECK != 0) ? S_PARITY : S_STOP;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_PARITY: begin
          r_tx    <= (P_UART_CHECK == 1) ? ~r_par : r_par;
          r_busy  <= 1'b1;
          r_state <= S_STOP;
        end
        S_STOP: begin
          r_tx   <= 1'b1;
          r_busy <= 1'b1;
          if (r_cnt == c_last_stop) begin
            r_cnt <= 4'd0;
            // Reload here so a queued word starts with no idle gap
            if (r_hold_full) begin
              r_shift     <= r_hold_data;
              r_hold_full <= 1'b0;
              r_ready     <= 1'b1;
              r_state     <= S_START;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        default: begin
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_uart_tx       = r_tx;
  assign o_uart_tx_busy  = r_busy;
  assign o_uart_tx_ready = r_ready;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_framer.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_framer
// Description : Directed bench for uart_tx_framer in 8N1, 8O1, 8E1 and 8N2.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_framer;

  logic       clk;
  logic       rst_n;
  logic [3:0] valid_v;
  logic [7:0] data_v [4];
  wire  [3:0] tx_v;
  wire  [3:0] busy_v;
  wire  [3:0] ready_v;

  int n_cmp;
  int n_fail;

  // index 0: 8N1, 1: 8O1, 2: 8E1, 3: 8N2
  uart_tx_framer #(.P_UART_DATA_WIDTH(8), .P_UART_STOP_WIDTH(1), .P_UART_CHECK(0)) dut_n1 (
    .i_u_clk(clk), .i_u_rst_n(rst_n), .i_uart_tx_data(data_v[0]), .i_uart_tx_valid(valid_v[0]),
    .o_uart_tx_ready(ready_v[0]), .o_uart_tx(tx_v[0]), .o_uart_tx_busy(busy_v[0]));
  uart_tx_framer #(.P_UART_DATA_WIDTH(8), .P_UART_STOP_WIDTH(1), .P_UART_CHECK(1)) dut_o1 (
    .i_u_clk(clk), .i_u_rst_n(rst_n), .i_uart_tx_data(data_v[1]), .i_uart_tx_valid(valid_v[1]),
    .o_uart_tx_ready(ready_v[1]), .o_uart_tx(tx_v[1]), .o_uart_tx_busy(busy_v[1]));
  uart_tx_framer #(.P_UART_DATA_WIDTH(8), .P_UART_STOP_WIDTH(1), .P_UART_CHECK(2)) dut_e1 (
    .i_u_clk(clk), .i_u_rst_n(rst_n), .i_uart_tx_data(data_v[2]), .i_uart_tx_valid(valid_v[2]),
    .o_uart_tx_ready(ready_v[2]), .o_uart_tx(tx_v[2]), .o_uart_tx_busy(busy_v[2]));
  uart_tx_framer #(.P_UART_DATA_WIDTH(8), .P_UART_STOP_WIDTH(2), .P_UART_CHECK(0)) dut_n2 (
    .i_u_clk(clk), .i_u_rst_n(rst_n), .i_uart_tx_data(data_v[3]), .i_uart_tx_valid(valid_v[3]),
    .o_uart_tx_ready(ready_v[3]), .o_uart_tx(tx_v[3]), .o_uart_tx_busy(busy_v[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int chk_of(input int sel);
    return (sel == 1) ? 1 : (sel == 2) ? 2 : 0;
  endfunction

  function automatic int stp_of(input int sel);
    return (sel == 3) ? 2 : 1;
  endfunction

  // Starts and ends just after a falling edge; returns after the load edge.
  task automatic send(input int sel, input logic [7:0] d);
    valid_v[sel] = 1'b1;
    data_v[sel]  = d;
    @(negedge clk);
    chk("send_ready_low", ready_v[sel], 1'b0);
    valid_v[sel] = 1'b0;
    @(negedge clk);
    chk("load_ready_high", ready_v[sel], 1'b1);
    chk("load_tx_idle", tx_v[sel], 1'b1);
  endtask

  task automatic check_bits(input int sel, input logic [15:0] bits, input int len, input string tag);
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      chk(tag, tx_v[sel], bits[i]);
      chk("frame_busy", busy_v[sel], 1'b1);
    end
    @(negedge clk);
    chk("post_frame_tx", tx_v[sel], 1'b1);
    chk("post_frame_busy", busy_v[sel], 1'b0);
  endtask

  // Decodes one frame from the line, including the idle cycle after it.
  task automatic rx_frame(input int sel, output logic [7:0] w, output logic p, output logic ok);
    int c = chk_of(sel);
    int s = stp_of(sel);
    ok = 1'b1;
    w  = 8'h00;
    p  = 1'b0;
    @(negedge clk);
    if (tx_v[sel] !== 1'b0 || busy_v[sel] !== 1'b1) ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      w[i] = tx_v[sel];
      if (busy_v[sel] !== 1'b1) ok = 1'b0;
    end
    if (c != 0) begin
      @(negedge clk);
      p = tx_v[sel];
    end
    for (int i = 0; i < s; i++) begin
      @(negedge clk);
      if (tx_v[sel] !== 1'b1 || busy_v[sel] !== 1'b1) ok = 1'b0;
    end
    @(negedge clk);
    if (tx_v[sel] !== 1'b1 || busy_v[sel] !== 1'b0) ok = 1'b0;
  endtask

  initial begin
    logic [7:0]  w;
    logic [7:0]  d;
    logic        p;
    logic        ok;
    logic        exp_p;
    logic [15:0] f55;
    logic [15:0] faa;
    logic [15:0] f5a;

    n_cmp   = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    valid_v = 4'b0000;
    for (int i = 0; i < 4; i++) data_v[i] = 8'h00;

    // Reset state of every configuration
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk("rst_tx", tx_v[i], 1'b1);
      chk("rst_ready", ready_v[i], 1'b1);
      chk("rst_busy", busy_v[i], 1'b0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // 8N1 0xA5: line 0,1,0,1,0,0,1,0,1,1
    send(0, 8'hA5);
    check_bits(0, 16'b0000_0011_0100_1010, 10, "n1_a5_bit");

    // 8O1 / 8E1 parity
    send(1, 8'h03);
    rx_frame(1, w, p, ok);
    chk("o1_03_word", w, 8'h03);
    chk("o1_03_par", p, 1'b1);
    chk("o1_03_frame", ok, 1'b1);
    send(2, 8'h07);
    rx_frame(2, w, p, ok);
    chk("e1_07_word", w, 8'h07);
    chk("e1_07_par", p, 1'b1);
    chk("e1_07_frame", ok, 1'b1);
    send(2, 8'h00);
    rx_frame(2, w, p, ok);
    chk("e1_00_word", w, 8'h00);
    chk("e1_00_par", p, 1'b0);
    chk("e1_00_frame", ok, 1'b1);

    // Back-to-back on 8N1: 0x55 then 0xAA with no idle gap
    f55 = 16'b0000_0010_1010_1010;
    faa = 16'b0000_0011_0101_0100;
    valid_v[0] = 1'b1;
    data_v[0]  = 8'h55;
    @(negedge clk);
    chk("b2b_acc1_ready", ready_v[0], 1'b0);
    data_v[0] = 8'hAA;
    @(negedge clk);
    chk("b2b_load1_ready", ready_v[0], 1'b1);
    chk("b2b_load1_tx", tx_v[0], 1'b1);
    @(negedge clk);
    chk("b2b_f1_start", tx_v[0], 1'b0);
    chk("b2b_acc2_ready", ready_v[0], 1'b0);
    valid_v[0] = 1'b0;
    for (int i = 1; i < 10; i++) begin
      @(negedge clk);
      chk("b2b_f1_bit", tx_v[0], f55[i]);
      chk("b2b_f1_busy", busy_v[0], 1'b1);
      chk("b2b_f1_ready", ready_v[0], (i == 9) ? 1'b1 : 1'b0);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("b2b_f2_bit", tx_v[0], faa[i]);
      chk("b2b_f2_busy", busy_v[0], 1'b1);
      chk("b2b_f2_ready", ready_v[0], 1'b1);
    end
    @(negedge clk);
    chk("b2b_idle_tx", tx_v[0], 1'b1);
    chk("b2b_idle_busy", busy_v[0], 1'b0);

    // 8N2 with valid held: frames of 0x5A repeat every 11 cycles
    f5a = 16'b0000_0110_1011_0100;
    valid_v[3] = 1'b1;
    data_v[3]  = 8'h5A;
    @(negedge clk);
    chk("n2_acc_ready", ready_v[3], 1'b0);
    @(negedge clk);
    chk("n2_load_ready", ready_v[3], 1'b1);
    for (int i = 0; i < 33; i++) begin
      @(negedge clk);
      chk("n2_bit", tx_v[3], f5a[i % 11]);
      chk("n2_busy", busy_v[3], 1'b1);
      if (i == 11) valid_v[3] = 1'b0;
    end
    @(negedge clk);
    chk("n2_idle_tx", tx_v[3], 1'b1);
    chk("n2_idle_busy", busy_v[3], 1'b0);
    chk("n2_idle_ready", ready_v[3], 1'b1);

    // Reset in the middle of 0x3C, with 0x81 waiting in the holding register
    valid_v[0] = 1'b1;
    data_v[0]  = 8'h3C;
    @(negedge clk);
    data_v[0] = 8'h81;
    @(negedge clk);
    @(negedge clk);
    chk("rstm_start", tx_v[0], 1'b0);
    chk("rstm_hold_full", ready_v[0], 1'b0);
    valid_v[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rstm_bit", tx_v[0], (i >= 2) ? 1'b1 : 1'b0);
    end
    @(posedge clk);
    #2;
    chk("rstm_busy_pre", busy_v[0], 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rstm_async_tx", tx_v[0], 1'b1);
    chk("rstm_async_busy", busy_v[0], 1'b0);
    chk("rstm_async_ready", ready_v[0], 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rstm_after_tx", tx_v[0], 1'b1);
      chk("rstm_after_busy", busy_v[0], 1'b0);
    end
    send(0, 8'h3C);
    check_bits(0, 16'b0000_0010_0111_1000, 10, "rstm_clean_bit");

    // Loopback decode of random words in every configuration
    for (int s = 0; s < 4; s++) begin
      for (int n = 0; n < 256; n++) begin
        d = 8'($urandom_range(0, 255));
        exp_p = (chk_of(s) == 1) ? ~^d : (chk_of(s) == 2) ? ^d : 1'b0;
        send(s, d);
        rx_frame(s, w, p, ok);
        chk("lb_word", w, d);
        chk("lb_par", p, exp_p);
        chk("lb_frame", ok, 1'b1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
